// File: rtl/prime_pkg.sv
// Shared types and defaults for the prime sieve generator.
package prime_pkg;

  localparam int PRIME_N_MAX = 1024;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    OUTER,
    MARK,
    SCAN,
    EMIT,
    DONE_ST
  } state_t;

endpackage

// File: rtl/prime_bitmap.sv
// N_MAX x 1 composite-flag store: one synchronous write port, one combinational read port.
module prime_bitmap #(
  parameter int N_MAX = 1024,
  parameter int W     = $clog2(N_MAX)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic         wdata,
  input  logic [W-1:0] raddr,
  output logic         rdata
);

  logic mem [N_MAX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prime_sieve_gen.sv
// Sieve of Eratosthenes over 0..limit; streams primes ascending on a valid/ready port.
module prime_sieve_gen
  import prime_pkg::*;
#(
  parameter int N_MAX = PRIME_N_MAX,
  parameter int W     = $clog2(N_MAX)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] limit,
  output logic         busy,
  output logic [W-1:0] prime,
  output logic         prime_valid,
  input  logic         prime_ready,
  output logic         done,
  output logic [W-1:0] count
);

  state_t state, state_nx;

  logic [W-1:0]   lim_q, lim_nx;
  logic [W-1:0]   i_q, i_nx;
  logic [W-1:0]   j_q, j_nx;
  logic [W:0]     k_q, k_nx;      // one bit wider so k can pass N_MAX-1 without wrapping
  logic [W-1:0]   prime_nx, count_nx;
  logic           pv_nx, done_nx, busy_nx;

  logic [2*W-1:0] sq;
  logic [W:0]     j_sum;
  logic           we, wdata, rdata;
  logic [W-1:0]   waddr, raddr;

  assign sq    = {{W{1'b0}}, i_q} * {{W{1'b0}}, i_q};
  assign j_sum = {1'b0, j_q} + {1'b0, i_q};

  assign we    = (state == CLEAR) || (state == MARK);
  assign wdata = (state == MARK);
  assign waddr = (state == MARK) ? j_q : k_q[W-1:0];
  assign raddr = (state == OUTER) ? i_q : k_q[W-1:0];

  prime_bitmap #(.N_MAX(N_MAX), .W(W)) u_bitmap (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      lim_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      prime       <= '0;
      prime_valid <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      count       <= '0;
    end else begin
      state       <= state_nx;
      lim_q       <= lim_nx;
      i_q         <= i_nx;
      j_q         <= j_nx;
      k_q         <= k_nx;
      prime       <= prime_nx;
      prime_valid <= pv_nx;
      done        <= done_nx;
      busy        <= busy_nx;
      count       <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lim_nx   = lim_q;
    i_nx     = i_q;
    j_nx     = j_q;
    k_nx     = k_q;
    prime_nx = prime;
    pv_nx    = prime_valid;
    done_nx  = 1'b0;
    busy_nx  = busy;
    count_nx = count;

    unique case (state)
      IDLE, DONE_ST: begin
        if (start) begin
          lim_nx   = limit;
          count_nx = '0;
          k_nx     = '0;
          busy_nx  = 1'b1;
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        if (k_q[W-1:0] == lim_q) begin
          i_nx     = W'(2);
          state_nx = OUTER;
        end else begin
          k_nx = k_q + 1'b1;
        end
      end
      OUTER: begin
        if (sq > {{W{1'b0}}, lim_q}) begin
          k_nx     = (W+1)'(2);
          state_nx = SCAN;
        end else if (rdata) begin
          i_nx = i_q + 1'b1;
        end else begin
          j_nx     = sq[W-1:0];
          state_nx = MARK;
        end
      end
      MARK: begin
        // a carry into bit W also lands here: the sum is past any legal limit
        if (j_sum > {1'b0, lim_q}) begin
          i_nx     = i_q + 1'b1;
          state_nx = OUTER;
        end else begin
          j_nx = j_sum[W-1:0];
        end
      end
      SCAN: begin
        if (k_q > {1'b0, lim_q}) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = DONE_ST;
        end else if (!rdata) begin
          prime_nx = k_q[W-1:0];
          pv_nx    = 1'b1;
          state_nx = EMIT;
        end else begin
          k_nx = k_q + 1'b1;
        end
      end
      EMIT: begin
        if (prime_ready) begin
          count_nx = count + 1'b1;
          pv_nx    = 1'b0;
          k_nx     = k_q + 1'b1;
          state_nx = SCAN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prime_sieve_gen.sv
// Randomised bench for prime_sieve_gen against a trial-division prime model.
module tb_prime_sieve_gen;

  localparam int N_MAX = 1024;
  localparam int W     = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] limit = '0;
  logic         prime_ready = 1'b0;
  logic         busy, prime_valid, done;
  logic [W-1:0] prime, count;

  prime_sieve_gen #(.N_MAX(N_MAX), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .limit      (limit),
    .busy       (busy),
    .prime      (prime),
    .prime_valid(prime_valid),
    .prime_ready(prime_ready),
    .done       (done),
    .count      (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int got_q[$];
  int done_cnt, stall_err, valid_seen;
  bit timed_out;

  function automatic void build_model(input int lim);
    exp_q.delete();
    for (int n = 2; n <= lim; n++) begin
      bit is_p = 1'b1;
      for (int d = 2; d * d <= n; d++)
        if (n % d == 0) is_p = 1'b0;
      if (is_p) exp_q.push_back(n);
    end
  endfunction

  // Called at a negedge; returns at the following negedge after the start pulse.
  task automatic start_run(input int lim);
    limit = lim[W-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drains the output stream until done is seen; returns at that negedge.
  task automatic collect(input int pct, input int budget);
    bit           stalled = 1'b0;
    logic [W-1:0] held = '0;
    got_q.delete();
    done_cnt = 0; stall_err = 0; valid_seen = 0; timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (prime_valid) begin
        valid_seen++;
        if (stalled && prime !== held) stall_err++;
      end else if (stalled) begin
        stall_err++;
      end
      if (done) begin
        done_cnt++;
        timed_out = 1'b0;
        break;
      end
      prime_ready = (int'($urandom_range(99)) < pct);
      stalled = prime_valid && !prime_ready;
      held = prime;
      if (prime_valid && prime_ready) got_q.push_back(int'(prime));
      @(negedge clk);
    end
    prime_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (prime_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", prime_valid); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (count !== '0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
    n_checks++; if (prime !== '0) $display("FAIL reset_prime: got %0d expected 0", prime); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_primes_30;
    build_model(30);
    start_run(30);
    n_checks++; if (busy !== 1'b1) $display("FAIL p30_busy: got %b expected 1", busy); else n_pass++;
    collect(100, 2000);
    n_checks++; if (timed_out) $display("FAIL p30_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (got_q.size() != 10) $display("FAIL p30_size: got %0d expected 10", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      int g = (i < got_q.size()) ? got_q[i] : -1;
      n_checks++; if (g != exp_q[i]) $display("FAIL p30_prime[%0d]: got %0d expected %0d", i, g, exp_q[i]); else n_pass++;
    end
    n_checks++; if (count !== 10) $display("FAIL p30_count: got %0d expected 10", count); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL p30_busy_done: got %b expected 0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL p30_done_width: got %b expected 0", done); else n_pass++;
    n_checks++; if (count !== 10) $display("FAIL p30_count_hold: got %0d expected 10", count); else n_pass++;
  endtask

  task automatic test_small_limits;
    int lims[2] = '{1, 0};
    foreach (lims[n]) begin
      start_run(lims[n]);
      collect(100, 200);
      n_checks++; if (done_cnt != 1) $display("FAIL small%0d_done: got %0d expected 1", lims[n], done_cnt); else n_pass++;
      n_checks++; if (valid_seen != 0) $display("FAIL small%0d_valid: got %0d expected 0", lims[n], valid_seen); else n_pass++;
      n_checks++; if (count !== 0) $display("FAIL small%0d_count: got %0d expected 0", lims[n], count); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    start_run(7);
    collect(100, 500);
    n_checks++; if (timed_out) $display("FAIL b2b_first_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (count !== 4) $display("FAIL b2b_first_count: got %0d expected 4", count); else n_pass++;
    start_run(13);   // start lands on the done-pulse cycle
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept: got busy %b expected 1", busy); else n_pass++;
    build_model(13);
    collect(100, 500);
    n_checks++; if (got_q != exp_q) $display("FAIL b2b_list: got %0d primes expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (count !== 6) $display("FAIL b2b_count: got %0d expected 6", count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mid_mark_start;
    build_model(30);
    start_run(30);
    repeat (33) @(negedge clk);
    limit = 5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    limit = 30;
    collect(100, 2000);
    n_checks++; if (got_q != exp_q) $display("FAIL midmark_list: got %0d primes expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (count !== 10) $display("FAIL midmark_count: got %0d expected 10", count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    build_model(100);
    start_run(100);
    collect(30, 10000);
    n_checks++; if (timed_out) $display("FAIL bp_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (got_q.size() != 25) $display("FAIL bp_size: got %0d expected 25", got_q.size()); else n_pass++;
    n_checks++; if (got_q != exp_q) $display("FAIL bp_list: got %0d primes expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (stall_err != 0) $display("FAIL bp_stable: got %0d stall errors expected 0", stall_err); else n_pass++;
    n_checks++; if (count !== 25) $display("FAIL bp_count: got %0d expected 25", count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_full_range;
    build_model(N_MAX - 1);
    start_run(N_MAX - 1);
    collect(100, 20000);
    n_checks++; if (timed_out) $display("FAIL full_timeout: got timeout expected done"); else n_pass++;
    n_checks++; if (got_q.size() != 172) $display("FAIL full_size: got %0d expected 172", got_q.size()); else n_pass++;
    n_checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] != 1021)
      $display("FAIL full_last: got %0d expected 1021", (got_q.size() == 0) ? -1 : got_q[got_q.size()-1]);
    else n_pass++;
    n_checks++; if (got_q != exp_q) $display("FAIL full_list: got %0d primes expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (count !== 172) $display("FAIL full_count: got %0d expected 172", count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_emit;
    bit seen = 1'b0;
    prime_ready = 1'b0;
    start_run(30);
    for (int c = 0; c < 500 && !seen; c++) begin
      if (prime_valid) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!seen) $display("FAIL rst_emit_reach: got no prime_valid expected one"); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (prime_valid !== 1'b0) $display("FAIL rst_emit_valid: got %b expected 0", prime_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_emit_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_emit_done: got %b expected 0", done); else n_pass++;
    n_checks++; if (count !== 0) $display("FAIL rst_emit_count: got %0d expected 0", count); else n_pass++;
    n_checks++; if (prime !== 0) $display("FAIL rst_emit_prime: got %0d expected 0", prime); else n_pass++;
    build_model(10);
    start_run(10);
    collect(100, 1000);
    n_checks++; if (got_q != exp_q) $display("FAIL rst_emit_list: got %0d primes expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (count !== 4) $display("FAIL rst_emit_count_after: got %0d expected 4", count); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_primes_30;
    test_small_limits;
    test_back_to_back;
    test_mid_mark_start;
    test_backpressure;
    test_full_range;
    test_reset_mid_emit;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
